// File: rtl/sync_fifo_pkg.sv
// Width helpers shared by the interleaved FIFO and its banks.
// Pure functions only; no logic, no latency, no backpressure of its own.
package sync_fifo_pkg;

    function automatic int ptr_width(input int num_banks, input int bank_depth);
        return $clog2(num_banks * bank_depth);
    endfunction

    function automatic int cnt_width(input int num_banks, input int bank_depth);
        return ptr_width(num_banks, bank_depth) + 1;
    endfunction

    // Row address width; a single-row bank still needs a 1-bit index.
    function automatic int row_width(input int bank_depth);
        return (bank_depth > 1) ? $clog2(bank_depth) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_bank.sv
// One interleaved storage bank: 1 synchronous write port, 1 asynchronous read port.
// Write lands on the rising edge; read data follows raddr combinationally; no backpressure.
module sync_fifo_bank
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int AW         = row_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_interleaved_fifo.sv
// Valid/ready FIFO striped across NUM_BANKS banks; first-word-fall-through, 1-cycle write-to-read.
// in_ready/out_valid come from the registered count only; drops at full / empty pops set sticky flags.
module sync_interleaved_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_DEPTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1,
    localparam int CW        = cnt_width(NUM_BANKS, BANK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int FIFO_DEPTH = NUM_BANKS * BANK_DEPTH;
    localparam int PW         = CW - 1;
    localparam int BW         = $clog2(NUM_BANKS);
    localparam int RW         = row_width(BANK_DEPTH);

    typedef logic [CW-1:0] count_t;
    typedef logic [PW-1:0] ptr_t;

    localparam count_t DEPTH_C = count_t'(FIFO_DEPTH);
    localparam count_t AF_C    = count_t'(AF_LEVEL);
    localparam count_t AE_C    = count_t'(AE_LEVEL);

    if (NUM_BANKS < 2 || !is_pow2(NUM_BANKS)) begin : g_bad_banks
        $error("NUM_BANKS must be a power of two >= 2");
    end
    if (!is_pow2(BANK_DEPTH)) begin : g_bad_depth
        $error("BANK_DEPTH must be a power of two >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
        $error("AF_LEVEL out of range 1..FIFO_DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("AE_LEVEL out of range 0..FIFO_DEPTH-1");
    end

    ptr_t          wp, rp;
    count_t        cnt;
    logic          push, pop;
    logic [BW-1:0] wp_bank, rp_bank;
    logic [RW-1:0] wp_row, rp_row;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

    assign in_ready     = (cnt < DEPTH_C);
    assign out_valid    = (cnt != '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Low pointer bits pick the bank, so consecutive entries rotate across banks.
    assign wp_bank = wp[BW-1:0];
    assign rp_bank = rp[BW-1:0];

    if (BANK_DEPTH > 1) begin : g_rows
        assign wp_row = wp[PW-1:BW];
        assign rp_row = rp[PW-1:BW];
    end else begin : g_single_row
        assign wp_row = '0;
        assign rp_row = '0;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sync_fifo_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (push && !clear && (wp_bank == BW'(b))),
            .waddr (wp_row),
            .wdata (in_data),
            .raddr (rp_row),
            .rdata (bank_rdata[b])
        );
    end

    // Gate to zero when empty so unreset bank contents never reach the port.
    assign out_data = out_valid ? bank_rdata[rp_bank] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (out_ready && !out_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_interleaved_fifo.sv
// Directed bench for sync_interleaved_fifo: default 2x2 instance plus a 4x4 instance for pointer wrap.
module tb_sync_interleaved_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration instance
    logic       clear = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, almost_full, almost_empty, overflow, underflow;
    logic [7:0] out_data;
    logic [2:0] count;

    sync_interleaved_fifo #(
        .DATA_WIDTH(8), .NUM_BANKS(2), .BANK_DEPTH(2), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    // 4 banks x 4 rows instance
    logic       w_clear = 1'b0;
    logic [7:0] w_in_data = '0;
    logic       w_in_valid = 1'b0, w_out_ready = 1'b0;
    logic       w_in_ready, w_out_valid, w_almost_full, w_almost_empty, w_overflow, w_underflow;
    logic [7:0] w_out_data;
    logic [4:0] w_count;

    sync_interleaved_fifo #(
        .DATA_WIDTH(8), .NUM_BANKS(4), .BANK_DEPTH(4), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut_w (
        .clk(clk), .rst(rst), .clear(w_clear),
        .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .count(w_count), .almost_full(w_almost_full), .almost_empty(w_almost_empty),
        .overflow(w_overflow), .underflow(w_underflow)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] sb[$];
    logic [7:0] sb_w[$];
    int         m_cnt = 0, m_cnt_w = 0;
    logic       m_ovf = 1'b0, m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the default instance: drive, check pre-edge outputs, advance, check count.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic clr);
        logic acc, pp;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = clr;
        chk("in_ready",     in_ready,     (m_cnt < 4));
        chk("out_valid",    out_valid,    (m_cnt > 0));
        chk("almost_full",  almost_full,  (m_cnt >= 3));
        chk("almost_empty", almost_empty, (m_cnt <= 1));
        chk("overflow",     overflow,     m_ovf);
        chk("underflow",    underflow,    m_unf);
        acc = v && (m_cnt < 4);
        pp  = r && (m_cnt > 0);
        if (clr) begin
            sb.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pp) chk("out_data", out_data, sb.pop_front());
            if (acc) sb.push_back(d);
            if (v && !acc) m_ovf = 1'b1;
            if (r && m_cnt == 0) m_unf = 1'b1;
            m_cnt = m_cnt + int'(acc) - int'(pp);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        chk("count", count, m_cnt);
    endtask

    task automatic cyc_w(input logic v, input logic [7:0] d, input logic r);
        logic acc, pp;
        w_in_valid  = v;
        w_in_data   = d;
        w_out_ready = r;
        acc = v && (m_cnt_w < 16);
        pp  = r && (m_cnt_w > 0);
        chk("w_in_ready", w_in_ready, (m_cnt_w < 16));
        if (pp) chk("w_out_data", w_out_data, sb_w.pop_front());
        if (acc) sb_w.push_back(d);
        m_cnt_w = m_cnt_w + int'(acc) - int'(pp);
        @(posedge clk);
        #1;
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
        chk("w_count", w_count, m_cnt_w);
    endtask

    initial begin
        // Reset held for 5 cycles
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_in_ready",     in_ready,     1'b1);
        chk("rst_out_valid",    out_valid,    1'b0);
        chk("rst_count",        count,        3'd0);
        chk("rst_almost_empty", almost_empty, 1'b1);
        chk("rst_almost_full",  almost_full,  1'b0);
        chk("rst_overflow",     overflow,     1'b0);
        chk("rst_underflow",    underflow,    1'b0);
        chk("rst_out_data",     out_data,     8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill to full, one dropped write, then drain
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("fill_overflow", overflow, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_out_valid", out_valid, 1'b0);

        // Streaming with simultaneous push and pop
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("stream_count", count, 3'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap on the 4x4 instance
        for (int i = 0; i < 12; i++) cyc_w(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 12; i++) cyc_w(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) cyc_w(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        chk("wrap_full", w_in_ready, 1'b0);
        chk("wrap_almost_full", w_almost_full, 1'b1);
        for (int i = 0; i < 16; i++) cyc_w(1'b0, 8'h00, 1'b1);
        chk("wrap_empty", w_out_valid, 1'b0);

        // Clear overrides push/pop and resets sticky flags
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        cyc(1'b1, 8'hA4, 1'b1, 1'b1);
        chk("clear_out_valid", out_valid, 1'b0);
        chk("clear_underflow", underflow, 1'b0);

        // Underflow on empty
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("underflow_set", underflow, 1'b1);

        // Async reset between edges mid-fill
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count",     count,     3'd0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready",  in_ready,  1'b1);
        chk("arst_out_data",  out_data,  8'h00);
        chk("arst_underflow", underflow, 1'b0);
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 8'hC7, 1'b0, 1'b0);
        cyc(1'b1, 8'hC8, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
